// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries decoded operands and control into execute,
// supports stall/flush, raises a combinational load-use hazard, counts bubbles.
module id_ex_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_alu_src,
    input  logic             id_mem_rd,
    input  logic             id_mem_wr,
    input  logic             id_reg_wr,
    input  logic             id_mem_to_reg,
    input  logic [2:0]       id_alu_op,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_rd1,
    output logic [WIDTH-1:0] ex_rd2,
    output logic [WIDTH-1:0] ex_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_alu_src,
    output logic             ex_mem_rd,
    output logic             ex_mem_wr,
    output logic             ex_reg_wr,
    output logic             ex_mem_to_reg,
    output logic [2:0]       ex_alu_op,
    output logic             load_use_hazard,
    output logic [15:0]      bubble_cnt
);

    localparam logic [4:0] XZR = 5'd31;

    // Stage control: reset beats flush beats stall beats load. A stall holds
    // the current contents; a flush (even with stall) writes a bubble.
    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_imm;
    logic [4:0]       r_rd;
    logic             r_alu_src;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic             r_reg_wr;
    logic             r_mem_to_reg;
    logic [2:0]       r_alu_op;
    logic [15:0]      r_bubble_cnt;

    logic w_bubble_in;
    logic w_cnt_sat;
    logic w_rd_match;

    assign w_bubble_in = flush | (~stall & ~id_valid);
    assign w_cnt_sat   = &r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rd         <= XZR;
            r_alu_src    <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= 3'b000;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rd         <= XZR;
            r_alu_src    <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= 3'b000;
        end else if (!stall) begin
            r_valid      <= id_valid;
            r_pc         <= id_pc;
            r_rd1        <= id_rd1;
            r_rd2        <= id_rd2;
            r_imm        <= id_imm;
            r_rd         <= id_rd;
            r_alu_src    <= id_alu_src;
            // Side-effecting controls are gated so an invalid slot never writes.
            r_mem_rd     <= id_mem_rd & id_valid;
            r_mem_wr     <= id_mem_wr & id_valid;
            r_reg_wr     <= id_reg_wr & id_valid;
            r_mem_to_reg <= id_mem_to_reg;
            r_alu_op     <= id_alu_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_bubble_in && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    // XZR as a destination is never a real producer, so it cannot cause a hazard.
    assign w_rd_match = (r_rd != XZR) & ((r_rd == id_rn) | (r_rd == id_rm));
    assign load_use_hazard = r_valid & r_mem_rd & w_rd_match & id_valid;

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rd1        = r_rd1;
    assign ex_rd2        = r_rd2;
    assign ex_imm        = r_imm;
    assign ex_rd         = r_rd;
    assign ex_alu_src    = r_alu_src;
    assign ex_mem_rd     = r_mem_rd;
    assign ex_mem_wr     = r_mem_wr;
    assign ex_reg_wr     = r_reg_wr;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_alu_op     = r_alu_op;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: load, stall, flush, hazard, reset and
// bubble counter saturation, checked with immediate assertions.
module tb_id_ex_reg;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         flush;
    logic         id_valid;
    logic [W-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]   id_rn, id_rm, id_rd;
    logic         id_alu_src, id_mem_rd, id_mem_wr, id_reg_wr, id_mem_to_reg;
    logic [2:0]   id_alu_op;
    logic         ex_valid;
    logic [W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]   ex_rd;
    logic         ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mem_to_reg;
    logic [2:0]   ex_alu_op;
    logic         load_use_hazard;
    logic [15:0]  bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_reg #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_reg_wr(id_reg_wr), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_src(ex_alu_src),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
        .load_use_hazard(load_use_hazard), .bubble_cnt(bubble_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] pc, input logic [W-1:0] rd1,
                         input logic [W-1:0] imm, input logic [4:0] rd,
                         input logic mrd, input logic mwr, input logic rwr);
        id_valid  = v;
        id_pc     = pc;
        id_rd1    = rd1;
        id_rd2    = rd1 ^ 64'hFF;
        id_imm    = imm;
        id_rd     = rd;
        id_mem_rd = mrd;
        id_mem_wr = mwr;
        id_reg_wr = rwr;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_rn = 5'd0; id_rm = 5'd0; id_alu_src = 1'b0; id_mem_to_reg = 1'b0;
        id_alu_op = 3'b000;
        drive(1'b0, '0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);

        #3;
        check("rst_valid", ex_valid, 0);
        check("rst_rd", ex_rd, 31);
        check("rst_pc", ex_pc, 0);
        check("rst_cnt", bubble_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic load
        drive(1'b1, 64'h100, 64'h1234, 64'h8, 5'd5, 1'b0, 1'b0, 1'b1);
        id_alu_op = 3'b101; id_alu_src = 1'b1;
        tick();
        check("ld_rd1", ex_rd1, 64'h1234);
        check("ld_rd2", ex_rd2, 64'h12CB);
        check("ld_imm", ex_imm, 64'h8);
        check("ld_rd", ex_rd, 5);
        check("ld_reg_wr", ex_reg_wr, 1);
        check("ld_valid", ex_valid, 1);
        check("ld_pc", ex_pc, 64'h100);
        check("ld_alu_op", ex_alu_op, 3'b101);
        check("ld_alu_src", ex_alu_src, 1);
        check("ld_cnt", bubble_cnt, 0);

        // Stall for three edges while decode inputs change
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 64'h200 + W'(i), 64'hBEEF + W'(i), 64'h40, 5'(9 + i), 1'b1, 1'b1, 1'b0);
            id_alu_op = 3'(i);
            tick();
            check("stl_rd1", ex_rd1, 64'h1234);
            check("stl_rd", ex_rd, 5);
            check("stl_valid", ex_valid, 1);
            check("stl_mem_wr", ex_mem_wr, 0);
            check("stl_cnt", bubble_cnt, 0);
        end
        stall = 1'b0;

        // Load a memory read to r3 and probe the hazard detector
        drive(1'b1, 64'h300, 64'h0, 64'h10, 5'd3, 1'b1, 1'b0, 1'b1);
        id_mem_to_reg = 1'b1;
        tick();
        check("ldr_mem_rd", ex_mem_rd, 1);
        check("ldr_m2r", ex_mem_to_reg, 1);
        id_valid = 1'b1; id_rn = 5'd3; id_rm = 5'd0;
        #1 check("hz_rn", load_use_hazard, 1);
        id_rn = 5'd4; id_rm = 5'd5;
        #1 check("hz_none", load_use_hazard, 0);
        id_rm = 5'd3;
        #1 check("hz_rm", load_use_hazard, 1);
        id_valid = 1'b0;
        #1 check("hz_idinv", load_use_hazard, 0);

        drive(1'b1, 64'h310, 64'h0, 64'h0, 5'd31, 1'b1, 1'b0, 1'b1);
        tick();
        id_valid = 1'b1; id_rn = 5'd31; id_rm = 5'd31;
        #1 check("hz_xzr", load_use_hazard, 0);

        // A non-load producer never raises the hazard
        drive(1'b1, 64'h320, 64'h0, 64'h0, 5'd6, 1'b0, 1'b0, 1'b1);
        tick();
        id_valid = 1'b1; id_rn = 5'd6;
        #1 check("hz_noload", load_use_hazard, 0);

        // Stall and flush together behave as flush
        stall = 1'b1; flush = 1'b1;
        tick();
        check("sf_valid", ex_valid, 0);
        check("sf_rd", ex_rd, 31);
        check("sf_pc", ex_pc, 0);
        check("sf_alu_op", ex_alu_op, 0);
        check("sf_reg_wr", ex_reg_wr, 0);
        check("sf_cnt", bubble_cnt, 1);
        stall = 1'b0; flush = 1'b0;

        // Load of an invalid slot: controls gated, bubble counted
        drive(1'b0, 64'h400, 64'hAA, 64'h4, 5'd12, 1'b1, 1'b1, 1'b1);
        tick();
        check("iv_valid", ex_valid, 0);
        check("iv_mem_rd", ex_mem_rd, 0);
        check("iv_mem_wr", ex_mem_wr, 0);
        check("iv_reg_wr", ex_reg_wr, 0);
        check("iv_rd1", ex_rd1, 64'hAA);
        check("iv_cnt", bubble_cnt, 2);

        // Reset mid-cycle during a stall drops the held instruction
        drive(1'b1, 64'h500, 64'h55, 64'h0, 5'd7, 1'b0, 1'b0, 1'b1);
        tick();
        check("pre_valid", ex_valid, 1);
        check("pre_cnt", bubble_cnt, 2);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("amr_valid", ex_valid, 0);
        check("amr_reg_wr", ex_reg_wr, 0);
        check("amr_rd", ex_rd, 31);
        check("amr_cnt", bubble_cnt, 0);
        flush = 1'b1;
        tick();
        check("rh_valid", ex_valid, 0);
        check("rh_cnt", bubble_cnt, 0);
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(1'b1, 64'h600, 64'h66, 64'h2, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        check("post_valid", ex_valid, 1);
        check("post_rd", ex_rd, 8);
        check("post_cnt", bubble_cnt, 0);

        // Bubble counter saturation
        flush = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", bubble_cnt, 16'hFFFE);
        tick();
        check("sat_ffff", bubble_cnt, 16'hFFFF);
        tick();
        check("sat_hold", bubble_cnt, 16'hFFFF);
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 5'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check("sat_hold2", bubble_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
